// File: rtl/uart_rx.sv
// uart_rx: oversampling-free UART receiver (1 start, N data LSB first, 1 stop,
// no parity). The serial line is synchronised, each bit is sampled once at
// mid-bit by a down-counter, and finished words are handed to the consumer
// through a level-sensitive valid/ack handshake. Framing errors and overruns
// are reported as single-cycle pulses.
module uart_rx #(
  parameter int unsigned C_CLK_FRQ         = 100000000,
  parameter int unsigned C_UART_BAUD_RATE  = 115200,
  parameter int unsigned C_UART_DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         rx,
  output logic [C_UART_DATA_WIDTH-1:0] data,
  output logic                         valid,
  input  logic                         ack,
  output logic                         ferr,
  output logic                         ovr
);

  // Clocks per bit, rounded to nearest, and the half-bit offset to mid-bit.
  localparam int unsigned C_BIT_CYC  = (C_CLK_FRQ + C_UART_BAUD_RATE / 2) / C_UART_BAUD_RATE;
  localparam int unsigned C_HALF_CYC = C_BIT_CYC / 2;
  localparam int unsigned C_CNT_W    = $clog2(C_BIT_CYC) + 1;
  localparam int unsigned C_IDX_W    = $clog2(C_UART_DATA_WIDTH);

  localparam logic [C_CNT_W-1:0] C_HALF_LOAD = C_CNT_W'(C_HALF_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_BIT_LOAD  = C_CNT_W'(C_BIT_CYC - 1);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX  = C_IDX_W'(C_UART_DATA_WIDTH - 1);

  // Reject parameter sets the counter scheme cannot support.
  if (C_BIT_CYC < 4) begin : gBitCycCheck
    $error("uart_rx: clocks per bit must be at least 4");
  end
  if (C_UART_DATA_WIDTH < 2) begin : gWidthCheck
    $error("uart_rx: data width must be at least 2");
  end

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } stateT;

  stateT                        state;
  stateT                        stateNxt;
  logic                         rxMeta;
  logic                         rxs;
  logic [C_CNT_W-1:0]           cnt;
  logic [C_CNT_W-1:0]           cntNxt;
  logic [C_IDX_W-1:0]           bitIdx;
  logic [C_IDX_W-1:0]           bitIdxNxt;
  logic [C_UART_DATA_WIDTH-1:0] shiftReg;
  logic [C_UART_DATA_WIDTH-1:0] shiftNxt;
  logic                         cntZero;
  logic                         loadWord;
  logic                         ovrSet;
  logic                         ferrSet;

  // Two-flop synchroniser; idle-high reset value keeps the line looking idle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxs    <= rxMeta;
    end
  end

  // State, bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= WAIT_IDLE;
      cnt      <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNxt;
      cnt      <= cntNxt;
      bitIdx   <= bitIdxNxt;
      shiftReg <= shiftNxt;
    end
  end

  assign cntZero = (cnt == '0);

  // Next-state logic: mid-bit sampling and frame qualification.
  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    bitIdxNxt = bitIdx;
    shiftNxt  = shiftReg;
    loadWord  = 1'b0;
    ovrSet    = 1'b0;
    ferrSet   = 1'b0;

    case (state)
      WAIT_IDLE: begin
        // Only arm after the line has been seen idle, so a frame or break in
        // progress at reset release is not mis-framed.
        if (rxs) begin
          stateNxt = IDLE;
        end
      end

      IDLE: begin
        if (!rxs) begin
          cntNxt   = C_HALF_LOAD;
          stateNxt = START;
        end
      end

      START: begin
        if (!cntZero) begin
          cntNxt = cnt - C_CNT_W'(1);
        end else if (!rxs) begin
          cntNxt    = C_BIT_LOAD;
          bitIdxNxt = '0;
          stateNxt  = DATA;
        end else begin
          // Start bit did not survive to mid-bit: treat as a glitch.
          stateNxt = IDLE;
        end
      end

      DATA: begin
        if (!cntZero) begin
          cntNxt = cnt - C_CNT_W'(1);
        end else begin
          shiftNxt = {rxs, shiftReg[C_UART_DATA_WIDTH-1:1]};
          cntNxt   = C_BIT_LOAD;
          if (bitIdx == C_LAST_IDX) begin
            stateNxt = STOP;
          end else begin
            bitIdxNxt = bitIdx + C_IDX_W'(1);
          end
        end
      end

      STOP: begin
        if (!cntZero) begin
          cntNxt = cnt - C_CNT_W'(1);
        end else if (!rxs) begin
          ferrSet  = 1'b1;
          stateNxt = WAIT_IDLE;
        end else begin
          // A word can load when the slot is free or being freed this cycle.
          if (valid && !ack) begin
            ovrSet = 1'b1;
          end else begin
            loadWord = 1'b1;
          end
          stateNxt = IDLE;
        end
      end

      default: begin
        stateNxt = WAIT_IDLE;
      end
    endcase
  end

  // Output word, handshake and status pulses.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (loadWord) begin
        data  <= shiftReg;
        valid <= 1'b1;
      end else if (valid && ack) begin
        valid <= 1'b0;
      end
      ferr <= ferrSet;
      ovr  <= ovrSet;
    end
  end

endmodule
